// File: rtl/disp_timing_gen.sv
// Display timing generator: raster counters, sync/DE generation and paced
// pixel pull from an upstream valid/ready stream. All outputs are registered
// one cycle behind the counter position; pix_ready is combinational.
module disp_timing_gen #(
   parameter int H_SYNC = 4,
   parameter int H_BP   = 4,
   parameter int H_ACT  = 16,
   parameter int H_FP   = 4,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 2,
   parameter int V_ACT  = 8,
   parameter int V_FP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        VSYNC,
   output logic        HSYNC,
   output logic        DATA_ENABLE,
   output logic [23:0] DATA,
   output logic        frame_start,
   output logic        underflow,
   output logic        busy
);

   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
   localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
   localparam logic [HW-1:0] H_ACT_LO = HW'(H_SYNC + H_BP);
   localparam logic [HW-1:0] H_ACT_HI = HW'(H_SYNC + H_BP + H_ACT);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
   localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
   localparam logic [VW-1:0] V_ACT_LO = VW'(V_SYNC + V_BP);
   localparam logic [VW-1:0] V_ACT_HI = VW'(V_SYNC + V_BP + V_ACT);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   logic [1:0]    state;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          running;
   logic          h_last;
   logic          frame_last;
   logic          active;

   assign running    = (state != ST_IDLE);
   assign h_last     = (h_cnt == H_LAST);
   assign frame_last = h_last && (v_cnt == V_LAST);
   assign active     = running
                       && (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI)
                       && (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);

   assign pix_ready = active;
   assign busy      = running;

   // Run control: a stop request only takes effect at the end of a frame,
   // and re-asserting en while stopping resumes without touching the raster.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (en) state <= ST_RUN;
            ST_RUN:  if (!en) state <= frame_last ? ST_IDLE : ST_STOP;
            ST_STOP: begin
               if (en)              state <= ST_RUN;
               else if (frame_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Raster counters: held at the origin while idle so RUN always begins at (0,0).
   always_ff @(posedge clk) begin
      if (rst || !running) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Registered pixel bus; a missing pixel in an active slot goes out as 0 with DE high.
   always_ff @(posedge clk) begin
      if (rst || !running) begin
         HSYNC       <= 1'b0;
         VSYNC       <= 1'b0;
         DATA_ENABLE <= 1'b0;
         DATA        <= '0;
         frame_start <= 1'b0;
      end else begin
         HSYNC       <= (h_cnt < H_SYNC_E);
         VSYNC       <= (v_cnt < V_SYNC_E);
         DATA_ENABLE <= active;
         DATA        <= (active && pix_valid) ? pix_data : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)                        underflow <= 1'b0;
      else if (active && !pix_valid) underflow <= 1'b1;
   end

endmodule

// File: tb/tb_disp_timing_gen.sv
// Scoreboard bench for disp_timing_gen: the stimulus side runs a frame-position
// reference model and queues the expected registered outputs; a monitor pops
// and compares them after every clock edge.
module tb_disp_timing_gen;

   localparam int H_SYNC = 4, H_BP = 4, H_ACT = 16, H_FP = 4;
   localparam int V_SYNC = 2, V_BP = 2, V_ACT = 8, V_FP = 2;
   localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int F_TOT = H_TOT * V_TOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [23:0] pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_ready, VSYNC, HSYNC, DATA_ENABLE, frame_start, underflow, busy;
   logic [23:0] DATA;

   disp_timing_gen #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .VSYNC(VSYNC), .HSYNC(HSYNC),
      .DATA_ENABLE(DATA_ENABLE), .DATA(DATA), .frame_start(frame_start),
      .underflow(underflow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        de;
      logic        fs;
      logic        uf;
      logic        busy;
      logic [23:0] data;
   } obs_t;

   obs_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Reference model: running flag, linear position inside the frame, sticky underflow.
   bit          m_run = 1'b0;
   int          m_pos = 0;
   bit          m_uf = 1'b0;
   bit          armed = 1'b0;
   bit          last_act = 1'b0;
   logic [23:0] next_pix = 24'd1;
   int          hs_cnt = 0;
   int          de_cnt = 0;
   bit          cnt_on = 1'b0;

   task automatic cyc(input logic en_i, input logic rst_i, input logic valid_i,
                      input logic [23:0] data_i);
      int   h, v;
      bit   act;
      obs_t e;
      @(negedge clk);
      en = en_i; rst = rst_i; pix_valid = valid_i; pix_data = data_i;
      #1;
      h   = m_pos % H_TOT;
      v   = m_pos / H_TOT;
      act = m_run && (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT)
                  && (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
      if (armed) begin
         n_cmp++;
         if (pix_ready !== act) begin
            n_bad++;
            $display("FAIL pix_ready at v=%0d h=%0d: actual %0b required %0b", v, h, pix_ready, act);
         end
         if (cnt_on && valid_i && pix_ready) hs_cnt++;
      end
      e = '0;
      if (rst_i) begin
         m_run = 1'b0; m_pos = 0; m_uf = 1'b0;
      end else begin
         m_uf   = m_uf | (act && !valid_i);
         e.vs   = m_run && (v < V_SYNC);
         e.hs   = m_run && (h < H_SYNC);
         e.de   = act;
         e.fs   = m_run && (m_pos == 0);
         e.uf   = m_uf;
         e.data = (act && valid_i) ? data_i : 24'd0;
         if (!m_run) begin
            if (en_i) m_run = 1'b1;
            m_pos = 0;
         end else begin
            if (m_pos == F_TOT - 1 && !en_i) m_run = 1'b0;
            m_pos = (m_pos + 1) % F_TOT;
         end
         e.busy = m_run;
      end
      last_act = act;
      exp_q.push_back(e);
      armed = 1'b1;
   endtask

   // Sequential pixel source: the counter advances only on an accepted pixel.
   task automatic px(input logic en_i, input logic valid_i);
      cyc(en_i, 1'b0, valid_i, valid_i ? next_pix : 24'd0);
      if (valid_i && last_act) next_pix = next_pix + 24'd1;
   endtask

   task automatic run_to(input int target, input logic en_i);
      for (int i = 0; i < F_TOT + 2 && m_pos != target; i++) px(en_i, 1'b1);
   endtask

   // Monitor: compare the registered outputs produced by each edge.
   initial begin : monitor
      obs_t e, got;
      forever begin
         @(posedge clk);
         #1;
         if (cnt_on && DATA_ENABLE) de_cnt++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {VSYNC, HSYNC, DATA_ENABLE, frame_start, underflow, busy, DATA};
            n_cmp++;
            if (got !== e) begin
               n_bad++;
               $display("FAIL outputs @%0t: actual vs%0b hs%0b de%0b fs%0b uf%0b busy%0b data=%06h required vs%0b hs%0b de%0b fs%0b uf%0b busy%0b data=%06h",
                        $time, got.vs, got.hs, got.de, got.fs, got.uf, got.busy, got.data,
                        e.vs, e.hs, e.de, e.fs, e.uf, e.busy, e.data);
            end
         end
      end
   end

   initial begin : stim
      logic en_r;
      // Reset, then idle with en low.
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 24'd0);
      repeat (50) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 24'($urandom));

      // Streaming frame with sequential pixels 1..128.
      next_pix = 24'd1;
      repeat (F_TOT + 2) px(1'b1, 1'b1);

      // Missing 5th pixel of active line 0.
      run_to((V_SYNC + V_BP) * H_TOT + H_SYNC + H_BP + 4, 1'b1);
      px(1'b1, 1'b0);
      run_to(0, 1'b1);

      // en dropped mid-frame and re-raised: back-to-back frame.
      run_to(5 * H_TOT + 10, 1'b1);
      run_to(9 * H_TOT, 1'b0);
      run_to(10, 1'b1);

      // en dropped mid-frame and left low: frame completes, then idle.
      run_to(5 * H_TOT + 10, 1'b1);
      repeat (F_TOT) px(1'b0, 1'b1);

      // Reset mid active line with en held high.
      repeat (2) px(1'b1, 1'b1);
      run_to(6 * H_TOT + 12, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, next_pix);
      repeat (F_TOT + 10) px(1'b1, 1'b1);

      // Three frames of continuous stream: handshake and DE counts.
      run_to(0, 1'b1);
      hs_cnt = 0; de_cnt = 0; cnt_on = 1'b1;
      repeat (3 * F_TOT) px(1'b1, 1'b1);
      @(posedge clk); #2;
      cnt_on = 1'b0;
      n_cmp++;
      if (hs_cnt != 3 * H_ACT * V_ACT) begin
         n_bad++;
         $display("FAIL handshakes_3frames: actual %0d required %0d", hs_cnt, 3 * H_ACT * V_ACT);
      end
      n_cmp++;
      if (de_cnt != 3 * H_ACT * V_ACT) begin
         n_bad++;
         $display("FAIL de_cycles_3frames: actual %0d required %0d", de_cnt, 3 * H_ACT * V_ACT);
      end

      // Randomized: en toggles occasionally, gappy valid, rare resets.
      en_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) en_r = ~en_r;
         cyc(en_r, 1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 7) != 0), 24'($urandom));
      end

      repeat (2) @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
